seg_display_arbiter: RTL and testbench

- Shares the board's two 4-digit seven-segment banks (left: seg/an, right: seg1/an_right) between three display clients: 0 = song/mode name, 1 = score/speed readout, 2 = alert/countdown.
- Arbitrates ownership with fixed priority and a minimum hold time.
- Multiplexes the owner's 8-character frame onto the banks with a shared scan timer.
- Sits between the per-mode frame generators (name, score and alert logic) and the board pins.

---
 rtl/seg_display_arbiter.sv | 139 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - priority/hold arbiter sharing two 4-digit seven-segment banks
// between three frame clients, with a free-running shared digit scan.
module seg_display_arbiter #(
  parameter int SCAN_DIV    = 200000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  output logic [2:0]  grant,
  output logic [7:0]  seg,
  output logic [7:0]  seg1,
  output logic [3:0]  an,
  output logic [3:0]  an_right
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state, state_n;
  logic [2:0]    grant_n;
  logic [HW-1:0] hold, hold_n;
  logic [PW-1:0] prescaler;
  logic [1:0]    digit;
  logic          tick;
  logic [2:0]    winner;
  logic [63:0]   owner_frame;

  function automatic logic [2:0] top_req(input logic [2:0] r);
    if (r[2])      return 3'b100;
    else if (r[1]) return 3'b010;
    else if (r[0]) return 3'b001;
    else           return 3'b000;
  endfunction

  assign tick   = (prescaler == PRE_LAST);
  assign winner = top_req(req);

  // Scan timer never restarts on ownership changes, so digits keep a steady cadence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      digit     <= 2'd0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        digit     <= digit + 2'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 3'b000;
      hold  <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      hold  <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    hold_n  = hold;
    case (state)
      IDLE: begin
        if (req != 3'b000) begin
          grant_n = winner;
          hold_n  = HOLD_LOAD;
          state_n = OWN;
        end
      end
      OWN: begin
        if (hold != '0) hold_n = hold - 1'b1;
        if ((req & grant) == 3'b000) begin
          if (req != 3'b000) begin
            grant_n = winner;
            hold_n  = HOLD_LOAD;
          end else begin
            grant_n = 3'b000;
            hold_n  = '0;
            state_n = IDLE;
          end
        // One-hot grants compare numerically in priority order.
        end else if ((hold == '0) && (winner > grant)) begin
          grant_n = winner;
          hold_n  = HOLD_LOAD;
        end
      end
      default: begin
        grant_n = 3'b000;
        hold_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    owner_frame = 64'd0;
    case (grant)
      3'b001:  owner_frame = frame0;
      3'b010:  owner_frame = frame1;
      3'b100:  owner_frame = frame2;
      default: owner_frame = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg      <= 8'd0;
      seg1     <= 8'd0;
      an       <= 4'b0000;
      an_right <= 4'b0000;
    end else if (grant == 3'b000) begin
      seg      <= 8'd0;
      seg1     <= 8'd0;
      an       <= 4'b0000;
      an_right <= 4'b0000;
    end else begin
      seg      <= owner_frame[{digit, 3'b000} +: 8];
      seg1     <= owner_frame[{1'b1, digit, 3'b000} +: 8];
      an       <= 4'b0001 << digit;
      an_right <= 4'b0001 << digit;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed bench for seg_display_arbiter (SCAN_DIV=4, HOLD_CYCLES=10)
module tb_seg_display_arbiter;

  localparam logic [63:0] F0 = 64'h0807060504030201;
  localparam logic [63:0] F1 = 64'h1817161514131211;
  localparam logic [63:0] F2 = 64'h2827262524232221;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [63:0] frame0, frame1, frame2;
  logic [2:0]  grant;
  logic [7:0]  seg, seg1;
  logic [3:0]  an, an_right;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg_display_arbiter #(.SCAN_DIV(4), .HOLD_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .grant(grant), .seg(seg), .seg1(seg1), .an(an), .an_right(an_right)
  );

  // Edge k after reset release: pins reflect the digit held after edge k-1, i.e. ((k-1)/4)%4.
  function automatic int pin_digit(input int k);
    return ((k - 1) / 4) % 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 3'b000;
    frame0 = F0; frame1 = F1; frame2 = F2;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({grant, seg, seg1, an, an_right} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got grant=%b seg=%h seg1=%h an=%b an_right=%b, want all zero",
               grant, seg, seg1, an, an_right);
    end
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if ({grant, seg, seg1, an, an_right} !== 27'd0) begin
        miscompares++;
        $display("FAIL idle_blank cyc=%0d: got grant=%b seg=%h seg1=%h an=%b, want all zero",
                 cyc, grant, seg, seg1, an);
      end
    end
  endtask

  task automatic test_scan();
    logic [63:0] f;
    logic [3:0]  seen;
    int d;
    f = F0;
    seen = 4'b0000;
    req = 3'b001;
    step();
    vectors++;
    if (grant !== 3'b001 || seg !== 8'h00 || an !== 4'b0000) begin
      miscompares++;
      $display("FAIL scan_grant_latency: got grant=%b seg=%h an=%b, want 001/00/0000", grant, seg, an);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      d = pin_digit(cyc);
      seen[d] = 1'b1;
      vectors++;
      if (an !== (4'b0001 << d) || an_right !== (4'b0001 << d) ||
          seg !== f[8*d +: 8] || seg1 !== f[8*(d+4) +: 8]) begin
        miscompares++;
        $display("FAIL scan_digit cyc=%0d: got an=%b an_right=%b seg=%h seg1=%h, want an=%b seg=%h seg1=%h",
                 cyc, an, an_right, seg, seg1, 4'b0001 << d, f[8*d +: 8], f[8*(d+4) +: 8]);
      end
    end
    vectors++;
    if (seen !== 4'b1111) begin
      miscompares++;
      $display("FAIL scan_all_digits: got %b, want 1111", seen);
    end
    req = 3'b000;
    step();
    vectors++;
    if (grant !== 3'b000) begin
      miscompares++;
      $display("FAIL release_to_idle: got %b, want 000", grant);
    end
    step();
    vectors++;
    if ({seg, seg1, an, an_right} !== 24'd0) begin
      miscompares++;
      $display("FAIL blank_after_release: got seg=%h seg1=%h an=%b, want 0", seg, seg1, an);
    end
  endtask

  task automatic test_hold_preempt();
    logic [2:0]  exp;
    logic [63:0] f;
    int d;
    f = F1;
    req = 3'b001;
    step();
    vectors++;
    if (grant !== 3'b001) begin
      miscompares++;
      $display("FAIL hold_initial_grant: got %b, want 001", grant);
    end
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) req = 3'b011;
      step();
      exp = (i < 10) ? 3'b001 : 3'b010;
      vectors++;
      if (grant !== exp) begin
        miscompares++;
        $display("FAIL hold_preempt edge=%0d: got %b, want %b", i, grant, exp);
      end
    end
    step();
    d = pin_digit(cyc);
    vectors++;
    if (seg !== f[8*d +: 8] || seg1 !== f[8*(d+4) +: 8]) begin
      miscompares++;
      $display("FAIL preempt_display: got seg=%h seg1=%h, want %h %h", seg, seg1, f[8*d +: 8], f[8*(d+4) +: 8]);
    end
  endtask

  task automatic test_no_lower_preempt();
    int bad;
    bad = 0;
    req = 3'b011;
    for (int i = 0; i < 50; i++) begin
      step();
      vectors++;
      if (grant !== 3'b010) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("FAIL no_lower_preempt cyc=%0d: got %b, want 010", cyc, grant);
      end
    end
    req = 3'b001;
    step();
    vectors++;
    if (grant !== 3'b001) begin
      miscompares++;
      $display("FAIL drop_to_lower: got %b, want 001", grant);
    end
  endtask

  task automatic test_drop_to_higher();
    logic [63:0] f;
    int d;
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++;
      if (grant !== 3'b001) begin
        miscompares++;
        $display("FAIL drop_hold_keep edge=%0d: got %b, want 001", i, grant);
      end
    end
    req = 3'b100;
    step();
    vectors++;
    if (grant !== 3'b100) begin
      miscompares++;
      $display("FAIL drop_with_higher: got %b, want 100", grant);
    end
    step();
    f = F2;
    d = pin_digit(cyc);
    vectors++;
    if (seg !== f[8*d +: 8] || seg1 !== f[8*(d+4) +: 8] || an !== (4'b0001 << d)) begin
      miscompares++;
      $display("FAIL frame2_display: got seg=%h seg1=%h an=%b, want %h %h %b",
               seg, seg1, an, f[8*d +: 8], f[8*(d+4) +: 8], 4'b0001 << d);
    end
    frame2 = 64'hF8F7F6F5F4F3F2F1;
    f = frame2;
    step();
    d = pin_digit(cyc);
    vectors++;
    if (seg !== f[8*d +: 8] || seg1 !== f[8*(d+4) +: 8]) begin
      miscompares++;
      $display("FAIL live_frame: got seg=%h seg1=%h, want %h %h", seg, seg1, f[8*d +: 8], f[8*(d+4) +: 8]);
    end
    frame2 = F2;
  endtask

  task automatic test_reset_mid_own();
    logic [2:0] exp;
    req = 3'b010;
    step();
    vectors++;
    if (grant !== 3'b010) begin
      miscompares++;
      $display("FAIL regrant_client1: got %b, want 010", grant);
    end
    step();
    step();
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({grant, seg, seg1, an, an_right} !== 27'd0) begin
      miscompares++;
      $display("FAIL async_reset: got grant=%b seg=%h seg1=%h an=%b, want all zero", grant, seg, seg1, an);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    step();
    vectors++;
    if (grant !== 3'b010) begin
      miscompares++;
      $display("FAIL grant_after_reset: got %b, want 010", grant);
    end
    req = 3'b110;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp = (i < 10) ? 3'b010 : 3'b100;
      vectors++;
      if (grant !== exp) begin
        miscompares++;
        $display("FAIL hold_reload_after_reset edge=%0d: got %b, want %b", i, grant, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_scan();
    test_hold_preempt();
    test_no_lower_preempt();
    test_drop_to_higher();
    test_reset_mid_own();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
